// File: rtl/pll_reset_sequencer_if.sv
// PLL lock / system reset bundle between the PLL wrapper, the reset sequencer
// and the top-level reset distribution.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       sys_reset_n;
  logic [1:0] state;
  logic [7:0] lock_loss_count;

  modport master (
    output pll_locked,
    input  sys_reset_n,
    input  state,
    input  lock_loss_count
  );

  modport slave (
    input  pll_locked,
    output sys_reset_n,
    output state,
    output lock_loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Synchronises and filters PLL lock, holds system reset after lock, drops it on lock loss.
// Optional macro PLL_RESET_SEQ_LOSS_COUNT_EN enables the saturating lock-loss counter.
module pll_reset_sequencer #(
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned HOLD_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pll_reset_sequencer_if.slave    bus
);

  localparam int unsigned FW = $clog2(LOCK_FILTER + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  logic          s1_q, s2_q;
  state_e        state_q, state_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          sys_reset_n_q, sys_reset_n_d;
  logic          loss_bump;

  // Two-flop synchroniser; s2_q is the only view of lock the FSM ever gets.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.pll_locked;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_LOCK;
      filt_q        <= '0;
      hold_q        <= '0;
      sys_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      filt_q        <= filt_d;
      hold_q        <= hold_d;
      sys_reset_n_q <= sys_reset_n_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    filt_d    = filt_q;
    hold_d    = hold_q;
    loss_bump = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (!s2_q) begin
          filt_d = '0;
        end else if (filt_q == FW'(LOCK_FILTER - 1)) begin
          state_d = HOLD;
          filt_d  = '0;
          hold_d  = '0;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end
      HOLD: begin
        // Lock loss wins over hold expiry so sys_reset_n can never pulse high.
        if (!s2_q) begin
          state_d = WAIT_LOCK;
          filt_d  = '0;
          hold_d  = '0;
        end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (!s2_q) begin
          state_d   = WAIT_LOCK;
          filt_d    = '0;
          hold_d    = '0;
          loss_bump = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        filt_d  = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    sys_reset_n_d = (state_d == RUN);
  end

  assign bus.sys_reset_n = sys_reset_n_q;
  assign bus.state       = state_q;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (loss_bump && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) loss_q <= 8'd0;
    else          loss_q <= loss_d;
  end

  assign bus.lock_loss_count = loss_q;
`else
  logic unused_loss_bump;
  assign unused_loss_bump    = loss_bump;
  assign bus.lock_loss_count = 8'd0;
`endif

endmodule
